// File: rtl/bp_resolve_queue.sv
// bp_resolve_queue
// In-flight branch queue between fetch and the predictor update port.
// Fetch pushes predicted branches; execute resolves them oldest-first.
// Each resolution pops the head and emits one registered update beat.
// A misprediction also emits a redirect, empties the queue, and closes
// fetch_ready for RECOVER_CYC cycles while fetch restarts on the right path.
module bp_resolve_queue #(
  parameter int DEPTH       = 8,
  parameter int RECOVER_CYC = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_valid,
  input  logic [31:0]              fetch_pc,
  input  logic                     fetch_pred,
  input  logic [31:0]              fetch_target,
  output logic                     fetch_ready,
  input  logic                     resolve_valid,
  input  logic                     resolve_taken,
  input  logic [31:0]              resolve_target,
  output logic                     update_valid,
  output logic [31:0]              update_pc,
  output logic                     update_prediction,
  output logic                     update_actual,
  output logic [31:0]              update_target,
  output logic                     redirect_valid,
  output logic [31:0]              redirect_pc,
  output logic                     resolve_err,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;
  localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_LOAD = CW'(RECOVER_CYC - 1);

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_RECOVER = 1'b1
  } state_t;

  // A resolution disagrees with the prediction if the direction differs,
  // or both say taken but to different targets. A not-taken prediction
  // carries no meaningful target, so it is never compared.
  function automatic logic is_mispredict(
    input logic        pred,
    input logic [31:0] pred_tgt,
    input logic        taken,
    input logic [31:0] act_tgt
  );
    return (pred != taken) || (pred && taken && (pred_tgt != act_tgt));
  endfunction

  // Entry storage
  logic [31:0]   pc_mem_r   [DEPTH];
  logic          pred_mem_r [DEPTH];
  logic [31:0]   tgt_mem_r  [DEPTH];

  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  state_t        state_r;
  logic [CW-1:0] rec_cnt_r;
  logic          fetch_ready_r;

  logic          update_valid_r;
  logic [31:0]   update_pc_r;
  logic          update_prediction_r;
  logic          update_actual_r;
  logic [31:0]   update_target_r;
  logic          redirect_valid_r;
  logic [31:0]   redirect_pc_r;
  logic          resolve_err_r;

  logic [31:0]   head_pc_s;
  logic          head_pred_s;
  logic [31:0]   head_tgt_s;
  logic          empty_s;
  logic          pop_s;
  logic          mispredict_s;
  logic          push_s;
  logic          resolve_err_s;
  logic [PW-1:0] rd_ptr_next_s;
  logic [PW-1:0] wr_ptr_next_s;
  logic          full_next_s;
  logic [31:0]   redirect_pc_s;

  // Head decode, pop/push qualification and next-pointer computation
  always_comb begin
    head_pc_s     = pc_mem_r[rd_ptr_r[AW-1:0]];
    head_pred_s   = pred_mem_r[rd_ptr_r[AW-1:0]];
    head_tgt_s    = tgt_mem_r[rd_ptr_r[AW-1:0]];
    empty_s       = (rd_ptr_r == wr_ptr_r);
    pop_s         = resolve_valid && !empty_s;
    resolve_err_s = resolve_valid && empty_s;
    mispredict_s  = pop_s && is_mispredict(head_pred_s, head_tgt_s, resolve_taken, resolve_target);
    // fetch_ready is registered, so a full queue refuses a push even when a
    // pop lands in the same cycle; a flush throws away the wrong-path push.
    push_s        = fetch_valid && fetch_ready_r && !mispredict_s;

    if (resolve_taken) begin
      redirect_pc_s = resolve_target;
    end else begin
      redirect_pc_s = head_pc_s + 32'd4;
    end

    if (pop_s) begin
      rd_ptr_next_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_next_s = rd_ptr_r;
    end

    if (mispredict_s) begin
      wr_ptr_next_s = rd_ptr_r + PTR_ONE;
    end else if (push_s) begin
      wr_ptr_next_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_ptr_next_s = wr_ptr_r;
    end

    full_next_s = (rd_ptr_next_s[AW] != wr_ptr_next_s[AW]) &&
                  (rd_ptr_next_s[AW-1:0] == wr_ptr_next_s[AW-1:0]);
  end

  // Write an accepted push into the slot under the write pointer
  always_ff @(posedge clk) begin
    if (!rst && push_s) begin
      pc_mem_r[wr_ptr_r[AW-1:0]]   <= fetch_pc;
      pred_mem_r[wr_ptr_r[AW-1:0]] <= fetch_pred;
      tgt_mem_r[wr_ptr_r[AW-1:0]]  <= fetch_target;
    end
  end

  // Read/write pointer advance, including the flush on mispredict
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
    end else begin
      rd_ptr_r <= rd_ptr_next_s;
      wr_ptr_r <= wr_ptr_next_s;
    end
  end

  // RUN/RECOVER state machine; fetch_ready is registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_RUN;
      rec_cnt_r     <= '0;
      fetch_ready_r <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (mispredict_s) begin
            state_r       <= ST_RECOVER;
            rec_cnt_r     <= CNT_LOAD;
            fetch_ready_r <= 1'b0;
          end else begin
            fetch_ready_r <= !full_next_s;
          end
        end
        ST_RECOVER: begin
          if (rec_cnt_r == '0) begin
            state_r       <= ST_RUN;
            fetch_ready_r <= !full_next_s;
          end else begin
            rec_cnt_r     <= rec_cnt_r - CNT_ONE;
            fetch_ready_r <= 1'b0;
          end
        end
        default: begin
          state_r       <= ST_RUN;
          rec_cnt_r     <= '0;
          fetch_ready_r <= 1'b0;
        end
      endcase
    end
  end

  // Update / redirect / error beats; data fields hold between beats
  always_ff @(posedge clk) begin
    if (rst) begin
      update_valid_r      <= 1'b0;
      update_pc_r         <= 32'd0;
      update_prediction_r <= 1'b0;
      update_actual_r     <= 1'b0;
      update_target_r     <= 32'd0;
      redirect_valid_r    <= 1'b0;
      redirect_pc_r       <= 32'd0;
      resolve_err_r       <= 1'b0;
    end else begin
      update_valid_r   <= pop_s;
      redirect_valid_r <= mispredict_s;
      resolve_err_r    <= resolve_err_s;
      if (pop_s) begin
        update_pc_r         <= head_pc_s;
        update_prediction_r <= head_pred_s;
        update_actual_r     <= resolve_taken;
        update_target_r     <= resolve_target;
      end
      if (mispredict_s) begin
        redirect_pc_r <= redirect_pc_s;
      end
    end
  end

  assign fetch_ready       = fetch_ready_r;
  assign update_valid      = update_valid_r;
  assign update_pc         = update_pc_r;
  assign update_prediction = update_prediction_r;
  assign update_actual     = update_actual_r;
  assign update_target     = update_target_r;
  assign redirect_valid    = redirect_valid_r;
  assign redirect_pc       = redirect_pc_r;
  assign resolve_err       = resolve_err_r;
  assign occupancy         = wr_ptr_r - rd_ptr_r;

endmodule

// File: tb/tb_bp_resolve_queue.sv
// tb_bp_resolve_queue
// Directed vector table, a full-queue sequence and a randomized run, all
// cross-checked every cycle against a queue-based reference model.
module tb_bp_resolve_queue;

  localparam int DEPTH       = 8;
  localparam int RECOVER_CYC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_valid = 1'b0;
  logic [31:0] fetch_pc = 32'd0;
  logic        fetch_pred = 1'b0;
  logic [31:0] fetch_target = 32'd0;
  logic        fetch_ready;
  logic        resolve_valid = 1'b0;
  logic        resolve_taken = 1'b0;
  logic [31:0] resolve_target = 32'd0;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_prediction;
  logic        update_actual;
  logic [31:0] update_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        resolve_err;
  logic [3:0]  occupancy;

  int checks = 0;
  int failures = 0;

  bp_resolve_queue #(.DEPTH(DEPTH), .RECOVER_CYC(RECOVER_CYC)) dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_pred(fetch_pred),
    .fetch_target(fetch_target), .fetch_ready(fetch_ready),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .resolve_target(resolve_target),
    .update_valid(update_valid), .update_pc(update_pc),
    .update_prediction(update_prediction), .update_actual(update_actual),
    .update_target(update_target),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .resolve_err(resolve_err), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic        pred;
    logic [31:0] tgt;
  } ent_t;

  ent_t        mq[$];
  int          rec_left = 0;
  logic        m_ready = 1'b0;
  logic        m_uv = 1'b0;
  logic [31:0] m_upc = 32'd0;
  logic        m_upred = 1'b0;
  logic        m_uact = 1'b0;
  logic [31:0] m_utgt = 32'd0;
  logic        m_rdv = 1'b0;
  logic [31:0] m_rdpc = 32'd0;
  logic        m_err = 1'b0;

  task automatic model_edge();
    ent_t h;
    ent_t n;
    logic mis;
    mis = 1'b0;
    if (rst) begin
      mq.delete();
      rec_left = 0;
      m_ready = 1'b0;
      m_uv = 1'b0; m_upc = 32'd0; m_upred = 1'b0; m_uact = 1'b0; m_utgt = 32'd0;
      m_rdv = 1'b0; m_rdpc = 32'd0; m_err = 1'b0;
    end else begin
      m_uv = 1'b0; m_rdv = 1'b0; m_err = 1'b0;
      if (rec_left > 0) rec_left--;
      if (resolve_valid) begin
        if (mq.size() == 0) begin
          m_err = 1'b1;
        end else begin
          h = mq.pop_front();
          m_uv = 1'b1; m_upc = h.pc; m_upred = h.pred;
          m_uact = resolve_taken; m_utgt = resolve_target;
          mis = (h.pred != resolve_taken) ||
                (h.pred && resolve_taken && (h.tgt != resolve_target));
          if (mis) begin
            m_rdv = 1'b1;
            m_rdpc = resolve_taken ? resolve_target : h.pc + 32'd4;
            mq.delete();
            rec_left = RECOVER_CYC;
          end
        end
      end
      if (!mis && fetch_valid && m_ready) begin
        n.pc = fetch_pc; n.pred = fetch_pred; n.tgt = fetch_target;
        mq.push_back(n);
      end
      m_ready = (rec_left == 0) && (mq.size() < DEPTH);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".uv"},    {31'd0, update_valid},      {31'd0, m_uv});
    chk({tag, ".upc"},   update_pc,                  m_upc);
    chk({tag, ".upred"}, {31'd0, update_prediction}, {31'd0, m_upred});
    chk({tag, ".uact"},  {31'd0, update_actual},     {31'd0, m_uact});
    chk({tag, ".utgt"},  update_target,              m_utgt);
    chk({tag, ".rdv"},   {31'd0, redirect_valid},    {31'd0, m_rdv});
    chk({tag, ".rdpc"},  redirect_pc,                m_rdpc);
    chk({tag, ".err"},   {31'd0, resolve_err},       {31'd0, m_err});
    chk({tag, ".occ"},   {28'd0, occupancy},         mq.size());
    chk({tag, ".fr"},    {31'd0, fetch_ready},       {31'd0, m_ready});
  endtask

  // One clock: DUT and model both take the edge, outputs compared #1 later
  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk_model(tag);
  endtask

  task automatic set_in(input logic r, input logic fv, input logic [31:0] fpc, input logic fp,
                        input logic [31:0] ft, input logic rv, input logic rt, input logic [31:0] rtg);
    rst = r; fetch_valid = fv; fetch_pc = fpc; fetch_pred = fp; fetch_target = ft;
    resolve_valid = rv; resolve_taken = rt; resolve_target = rtg;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        r;
    logic        fv;
    logic [31:0] fpc;
    logic        fp;
    logic [31:0] ft;
    logic        rv;
    logic        rt;
    logic [31:0] rtg;
    logic        euv;
    logic [31:0] eupc;
    logic        erdv;
    logic [31:0] erdpc;
    logic        eerr;
    logic [3:0]  eocc;
    logic        efr;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic fv, input logic [31:0] fpc, input logic fp,
                              input logic [31:0] ft, input logic rv, input logic rt, input logic [31:0] rtg,
                              input logic euv, input logic [31:0] eupc, input logic erdv,
                              input logic [31:0] erdpc, input logic eerr, input logic [3:0] eocc,
                              input logic efr);
    vec_t v;
    v.r = r; v.fv = fv; v.fpc = fpc; v.fp = fp; v.ft = ft; v.rv = rv; v.rt = rt; v.rtg = rtg;
    v.euv = euv; v.eupc = eupc; v.erdv = erdv; v.erdpc = erdpc; v.eerr = eerr;
    v.eocc = eocc; v.efr = efr;
    return v;
  endfunction

  localparam int NV = 34;
  vec_t tbl[NV];

  initial begin
    logic [31:0] exp_pc;

    //          r    fv   fpc            fp   ft           rv   rt   rtg          | uv   upc            rdv  rdpc         err  occ   fr
    tbl[0]  = mk(1'b1,1'b0,32'h0,        1'b0,32'h0,       1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,       1'b0,4'd0,1'b0);
    tbl[1]  = mk(1'b0,1'b0,32'h0,        1'b0,32'h0,       1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,       1'b0,4'd0,1'b1);
    tbl[2]  = mk(1'b0,1'b1,32'h100,      1'b1,32'h400,     1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,       1'b0,4'd1,1'b1);
    tbl[3]  = mk(1'b0,1'b1,32'h200,      1'b1,32'h400,     1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,       1'b0,4'd2,1'b1);
    tbl[4]  = mk(1'b0,1'b1,32'h300,      1'b1,32'h400,     1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,       1'b0,4'd3,1'b1);
    tbl[5]  = mk(1'b0,1'b0,32'h0,        1'b0,32'h0,       1'b1,1'b1,32'h400,      1'b1,32'h100,      1'b0,32'h0,       1'b0,4'd2,1'b1);
    tbl[6]  = mk(1'b0,1'b0,32'h0,        1'b0,32'h0,       1'b1,1'b1,32'h400,      1'b1,32'h200,      1'b0,32'h0,       1'b0,4'd1,1'b1);
    tbl[7]  = mk(1'b0,1'b0,32'h0,        1'b0,32'h0,       1'b1,1'b1,32'h400,      1'b1,32'h300,      1'b0,32'h0,       1'b0,4'd0,1'b1);
    tbl[8]  = mk(1'b0,1'b0,32'h0,        1'b0,32'h0,       1'b0,1'b0,32'h0,        1'b0,32'h300,      1'b0,32'h0,       1'b0,4'd0,1'b1);
    tbl[9]  = mk(1'b0,1'b1,32'h1000,     1'b1,32'h2000,    1'b0,1'b0,32'h0,        1'b0,32'h300,      1'b0,32'h0,       1'b0,4'd1,1'b1);
    tbl[10] = mk(1'b0,1'b0,32'h0,        1'b0,32'h0,       1'b1,1'b1,32'h3000,     1'b1,32'h1000,     1'b1,32'h3000,    1'b0,4'd0,1'b0);
    tbl[11] = mk(1'b0,1'b0,32'h0,        1'b0,32'h0,       1'b0,1'b0,32'h0,        1'b0,32'h1000,     1'b0,32'h3000,    1'b0,4'd0,1'b0);
    tbl[12] = mk(1'b0,1'b0,32'h0,        1'b0,32'h0,       1'b0,1'b0,32'h0,        1'b0,32'h1000,     1'b0,32'h3000,    1'b0,4'd0,1'b1);
    tbl[13] = mk(1'b0,1'b1,32'h1000,     1'b1,32'h2000,    1'b0,1'b0,32'h0,        1'b0,32'h1000,     1'b0,32'h3000,    1'b0,4'd1,1'b1);
    tbl[14] = mk(1'b0,1'b1,32'h1100,     1'b0,32'h0,       1'b0,1'b0,32'h0,        1'b0,32'h1000,     1'b0,32'h3000,    1'b0,4'd2,1'b1);
    tbl[15] = mk(1'b0,1'b0,32'h0,        1'b0,32'h0,       1'b1,1'b0,32'h0,        1'b1,32'h1000,     1'b1,32'h1004,    1'b0,4'd0,1'b0);
    tbl[16] = mk(1'b0,1'b0,32'h0,        1'b0,32'h0,       1'b0,1'b0,32'h0,        1'b0,32'h1000,     1'b0,32'h1004,    1'b0,4'd0,1'b0);
    tbl[17] = mk(1'b0,1'b0,32'h0,        1'b0,32'h0,       1'b0,1'b0,32'h0,        1'b0,32'h1000,     1'b0,32'h1004,    1'b0,4'd0,1'b1);
    tbl[18] = mk(1'b0,1'b1,32'h4000,     1'b0,32'h0,       1'b0,1'b0,32'h0,        1'b0,32'h1000,     1'b0,32'h1004,    1'b0,4'd1,1'b1);
    tbl[19] = mk(1'b0,1'b1,32'h5000,     1'b1,32'h6000,    1'b1,1'b1,32'h4100,     1'b1,32'h4000,     1'b1,32'h4100,    1'b0,4'd0,1'b0);
    tbl[20] = mk(1'b0,1'b0,32'h0,        1'b0,32'h0,       1'b0,1'b0,32'h0,        1'b0,32'h4000,     1'b0,32'h4100,    1'b0,4'd0,1'b0);
    tbl[21] = mk(1'b0,1'b0,32'h0,        1'b0,32'h0,       1'b0,1'b0,32'h0,        1'b0,32'h4000,     1'b0,32'h4100,    1'b0,4'd0,1'b1);
    tbl[22] = mk(1'b0,1'b0,32'h0,        1'b0,32'h0,       1'b1,1'b1,32'h0,        1'b0,32'h4000,     1'b0,32'h4100,    1'b1,4'd0,1'b1);
    tbl[23] = mk(1'b0,1'b0,32'h0,        1'b0,32'h0,       1'b0,1'b0,32'h0,        1'b0,32'h4000,     1'b0,32'h4100,    1'b0,4'd0,1'b1);
    tbl[24] = mk(1'b0,1'b1,32'hFFFFFFFC, 1'b1,32'h10,      1'b0,1'b0,32'h0,        1'b0,32'h4000,     1'b0,32'h4100,    1'b0,4'd1,1'b1);
    tbl[25] = mk(1'b0,1'b0,32'h0,        1'b0,32'h0,       1'b1,1'b0,32'h0,        1'b1,32'hFFFFFFFC, 1'b1,32'h0,       1'b0,4'd0,1'b0);
    tbl[26] = mk(1'b0,1'b0,32'h0,        1'b0,32'h0,       1'b1,1'b0,32'h0,        1'b0,32'hFFFFFFFC, 1'b0,32'h0,       1'b1,4'd0,1'b0);
    tbl[27] = mk(1'b0,1'b0,32'h0,        1'b0,32'h0,       1'b0,1'b0,32'h0,        1'b0,32'hFFFFFFFC, 1'b0,32'h0,       1'b0,4'd0,1'b1);
    tbl[28] = mk(1'b0,1'b1,32'hA0,       1'b1,32'hB0,      1'b0,1'b0,32'h0,        1'b0,32'hFFFFFFFC, 1'b0,32'h0,       1'b0,4'd1,1'b1);
    tbl[29] = mk(1'b0,1'b1,32'hA4,       1'b1,32'hB0,      1'b0,1'b0,32'h0,        1'b0,32'hFFFFFFFC, 1'b0,32'h0,       1'b0,4'd2,1'b1);
    tbl[30] = mk(1'b0,1'b1,32'hA8,       1'b1,32'hB0,      1'b0,1'b0,32'h0,        1'b0,32'hFFFFFFFC, 1'b0,32'h0,       1'b0,4'd3,1'b1);
    tbl[31] = mk(1'b0,1'b1,32'hAC,       1'b1,32'hB0,      1'b0,1'b0,32'h0,        1'b0,32'hFFFFFFFC, 1'b0,32'h0,       1'b0,4'd4,1'b1);
    tbl[32] = mk(1'b1,1'b0,32'h0,        1'b0,32'h0,       1'b1,1'b1,32'hB0,       1'b0,32'h0,        1'b0,32'h0,       1'b0,4'd0,1'b0);
    tbl[33] = mk(1'b0,1'b0,32'h0,        1'b0,32'h0,       1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,       1'b0,4'd0,1'b1);

    #1;
    for (int i = 0; i < NV; i++) begin
      set_in(tbl[i].r, tbl[i].fv, tbl[i].fpc, tbl[i].fp, tbl[i].ft,
             tbl[i].rv, tbl[i].rt, tbl[i].rtg);
      tick($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.t_uv", i),   {31'd0, update_valid},   {31'd0, tbl[i].euv});
      chk($sformatf("vec%0d.t_upc", i),  update_pc,               tbl[i].eupc);
      chk($sformatf("vec%0d.t_rdv", i),  {31'd0, redirect_valid}, {31'd0, tbl[i].erdv});
      chk($sformatf("vec%0d.t_rdpc", i), redirect_pc,             tbl[i].erdpc);
      chk($sformatf("vec%0d.t_err", i),  {31'd0, resolve_err},    {31'd0, tbl[i].eerr});
      chk($sformatf("vec%0d.t_occ", i),  {28'd0, occupancy},      {28'd0, tbl[i].eocc});
      chk($sformatf("vec%0d.t_fr", i),   {31'd0, fetch_ready},    {31'd0, tbl[i].efr});
    end

    // ---------------- full-queue sequence ----------------
    set_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick("full.rst");
    rst = 1'b0;
    tick("full.idle");
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1'b0, 1'b1, 32'h800 + 32'(4 * i), 1'b1, 32'h900, 1'b0, 1'b0, 32'h0);
      tick($sformatf("full.push%0d", i));
    end
    chk("full.occ_depth", {28'd0, occupancy}, 32'd8);
    chk("full.fr_low",    {31'd0, fetch_ready}, 32'd0);
    // push while full, with a same-cycle pop: the push is dropped
    set_in(1'b0, 1'b1, 32'h7777, 1'b1, 32'h900, 1'b1, 1'b1, 32'h900);
    tick("full.drop");
    chk("full.drop_upc", update_pc, 32'h800);
    chk("full.drop_occ", {28'd0, occupancy}, 32'd7);
    chk("full.drop_fr",  {31'd0, fetch_ready}, 32'd1);
    // push + pop at DEPTH-1: count unchanged
    set_in(1'b0, 1'b1, 32'h8888, 1'b1, 32'h900, 1'b1, 1'b1, 32'h900);
    tick("full.pp");
    chk("full.pp_upc", update_pc, 32'h804);
    chk("full.pp_occ", {28'd0, occupancy}, 32'd7);
    for (int i = 0; i < 7; i++) begin
      set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h900);
      tick($sformatf("full.drain%0d", i));
      exp_pc = (i < 6) ? 32'h808 + 32'(4 * i) : 32'h8888;
      chk($sformatf("full.drain%0d_upc", i), update_pc, exp_pc);
    end
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick("full.end");
    chk("full.end_occ", {28'd0, occupancy}, 32'd0);

    // ---------------- randomized run ----------------
    for (int c = 0; c < 3000; c++) begin
      rst            = ($urandom_range(0, 299) == 0);
      fetch_valid    = ($urandom_range(0, 99) < 60);
      fetch_pc       = (($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : $urandom()) & 32'hFFFFFFFC;
      fetch_pred     = $urandom_range(0, 1) == 1;
      fetch_target   = $urandom() & 32'hFFFFFFFC;
      resolve_valid  = ($urandom_range(0, 99) < 45);
      if ((mq.size() > 0) && ($urandom_range(0, 99) < 75)) begin
        resolve_taken  = mq[0].pred;
        resolve_target = mq[0].pred ? mq[0].tgt : ($urandom() & 32'hFFFFFFFC);
      end else if ((mq.size() > 0) && ($urandom_range(0, 1) == 1)) begin
        resolve_taken  = 1'b1;
        resolve_target = mq[0].tgt ^ 32'h00000010;
      end else begin
        resolve_taken  = $urandom_range(0, 1) == 1;
        resolve_target = $urandom() & 32'hFFFFFFFC;
      end
      tick($sformatf("rnd%0d", c));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
